// File: rtl/debug_step_ctrl_pkg.sv
// Shared types for the SCPU host debug run/halt/step controller.
// Opcodes, controller states and the breakpoint-clear sentinel.
package debug_step_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_HALT   = 2'b00,
    CMD_RUN    = 2'b01,
    CMD_STEP   = 2'b10,
    CMD_SET_BP = 2'b11
  } dbg_cmd_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_STEP_HI = 2'd2,
    ST_STEP_LO = 2'd3
  } dbg_state_e;

  localparam logic [31:0] DBG_BP_CLEAR = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_step_ctrl.sv
// Run/halt/single-step controller driving debug_en/debug_step of the
// SCPU control unit, with a single fetch-PC breakpoint.
module debug_step_ctrl
  import debug_step_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit START_HALTED = 1'b0,
  parameter int STEP_LO_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      if_pc,
  output logic             debug_en,
  output logic             debug_step,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] steps_left
);

  localparam int LO_W =
    (STEP_LO_CYC < 2) ? 1 : $clog2(STEP_LO_CYC + 1);

  dbg_state_e       state_q, state_d;
  logic             bp_valid_q, bp_valid_d;
  logic [31:0]      bp_addr_q, bp_addr_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [LO_W-1:0]  lo_cnt_q, lo_cnt_d;
  logic             skip_q, skip_d;
  logic             en_q, step_q, halted_q;

  logic             accept;
  logic             bp_match;
  logic [CNT_W-1:0] arg_cnt;
  logic [CNT_W-1:0] step_load;
  dbg_cmd_e         op;

  assign cmd_ready = (state_q == ST_RUN) || (state_q == ST_HALT);
  assign accept    = cmd_valid && cmd_ready;
  assign bp_match  = bp_valid_q && (if_pc == bp_addr_q);
  assign arg_cnt   = cmd_arg[CNT_W-1:0];
  assign step_load = (arg_cnt == '0) ? CNT_W'(1) : arg_cnt;
  assign op        = dbg_cmd_e'(cmd_op);

  always_comb begin
    state_d    = state_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    bp_hit_d   = bp_hit_q;
    steps_d    = steps_q;
    lo_cnt_d   = lo_cnt_q;
    skip_d     = 1'b0;

    if (accept && op == CMD_SET_BP) begin
      bp_addr_d  = cmd_arg;
      bp_valid_d = (cmd_arg != DBG_BP_CLEAR);
    end

    unique case (state_q)
      ST_RUN: begin
        // skip_q masks the compare right after resuming at bp_addr
        if (bp_match && !skip_q) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else if (accept) begin
          if (op == CMD_HALT) begin
            state_d = ST_HALT;
          end else if (op == CMD_STEP) begin
            state_d  = ST_STEP_HI;
            steps_d  = step_load;
            bp_hit_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        if (accept) begin
          if (op == CMD_RUN) begin
            state_d  = ST_RUN;
            bp_hit_d = 1'b0;
            skip_d   = 1'b1;
          end else if (op == CMD_STEP) begin
            state_d  = ST_STEP_HI;
            steps_d  = step_load;
            bp_hit_d = 1'b0;
          end
        end
      end
      ST_STEP_HI: begin
        if (bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
          steps_d  = '0;
        end else begin
          steps_d = (steps_q == '0) ? '0 : steps_q - CNT_W'(1);
          if (steps_q <= CNT_W'(1)) begin
            state_d = ST_HALT;
          end else begin
            state_d  = ST_STEP_LO;
            lo_cnt_d = LO_W'(STEP_LO_CYC);
          end
        end
      end
      ST_STEP_LO: begin
        if (lo_cnt_q <= LO_W'(1)) begin
          state_d  = ST_STEP_HI;
          lo_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_cnt_q - LO_W'(1);
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START_HALTED ? ST_HALT : ST_RUN;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      bp_hit_q   <= 1'b0;
      steps_q    <= '0;
      lo_cnt_q   <= '0;
      skip_q     <= 1'b0;
      en_q       <= START_HALTED;
      step_q     <= 1'b0;
      halted_q   <= START_HALTED;
    end else begin
      state_q    <= state_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      bp_hit_q   <= bp_hit_d;
      steps_q    <= steps_d;
      lo_cnt_q   <= lo_cnt_d;
      skip_q     <= skip_d;
      en_q       <= (state_d != ST_RUN);
      step_q     <= (state_d == ST_STEP_HI);
      halted_q   <= (state_d == ST_HALT);
    end
  end

  assign debug_en   = en_q;
  assign debug_step = step_q;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Randomized bench for debug_step_ctrl against a
// step-pattern / breakpoint-sweep reference model.
module tb_debug_step_ctrl;

  localparam int CNT_W = 16;
  localparam int LO    = 1;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_BP   = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [31:0]      cmd_arg = '0;
  logic [31:0]      if_pc = 32'hFFFF_0000;
  logic             debug_en;
  logic             debug_step;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_step_ctrl #(
    .CNT_W(CNT_W),
    .START_HALTED(1'b1),
    .STEP_LO_CYC(LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .if_pc(if_pc),
    .debug_en(debug_en),
    .debug_step(debug_step),
    .halted(halted),
    .bp_hit(bp_hit),
    .steps_left(steps_left)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({debug_en, debug_step, halted, cmd_ready} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=1011",
               {debug_en, debug_step, halted, cmd_ready});
    end
    checks++;
    if ({bp_hit, steps_left} !== 17'd0) begin
      errors++;
      $display("FAIL reset_cnt got bp_hit=%b steps=%0d exp 0/0",
               bp_hit, steps_left);
    end
  endtask

  // From HALT: n = max(arg[15:0],1) pulses, one every LO+1 cycles.
  task automatic test_step(input logic [31:0] arg);
    int   n;
    int   last_hi;
    int   exp_steps;
    logic exp_pulse;
    logic exp_halt;
    n       = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]);
    last_hi = (n - 1) * (LO + 1);
    if_pc   = 32'hFFFF_0000;
    send(OP_STEP, arg);
    cmd_valid = 1'b1;
    cmd_op    = OP_HALT;
    for (int k = 0; k <= last_hi + 1; k++) begin
      exp_pulse = (k <= last_hi) && (k % (LO + 1) == 0);
      exp_halt  = (k > last_hi);
      exp_steps = exp_halt ? 0 : n - (k + LO) / (LO + 1);
      checks++;
      if ({debug_en, debug_step, halted, cmd_ready} !==
          {1'b1, exp_pulse, exp_halt, exp_halt}) begin
        errors++;
        $display("FAIL step_ctl n=%0d k=%0d got=%b exp=%b", n, k,
                 {debug_en, debug_step, halted, cmd_ready},
                 {1'b1, exp_pulse, exp_halt, exp_halt});
      end
      checks++;
      if (steps_left !== exp_steps[CNT_W-1:0]) begin
        errors++;
        $display("FAIL step_left n=%0d k=%0d got=%0d exp=%0d",
                 n, k, steps_left, exp_steps);
      end
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (bp_hit !== 1'b0) begin
      errors++;
      $display("FAIL step_bphit got=%b exp=0", bp_hit);
    end
  endtask

  task automatic test_breakpoint(input logic [31:0] bp);
    logic        hit;
    logic [31:0] pc;
    hit = 1'b0;
    send(OP_BP, bp);
    checks++;
    if ({halted, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL bp_set got=%b exp=11", {halted, cmd_ready});
    end
    if_pc = 32'hFFFF_0000;
    send(OP_RUN, 32'd0);
    for (int i = 0; i <= int'(bp / 4) + 2; i++) begin
      pc    = 32'(i * 4);
      if_pc = pc;
      tick();
      if (pc == bp) hit = 1'b1;
      checks++;
      if ({debug_en, halted, bp_hit} !== {hit, hit, hit}) begin
        errors++;
        $display("FAIL bp_sweep bp=%h pc=%h got=%b exp=%b", bp, pc,
                 {debug_en, halted, bp_hit}, {hit, hit, hit});
      end
    end
    if_pc = bp;
    send(OP_RUN, 32'd0);
    tick();
    checks++;
    if ({debug_en, bp_hit} !== 2'b00) begin
      errors++;
      $display("FAIL bp_resume got=%b exp=00", {debug_en, bp_hit});
    end
    if_pc = bp + 32'd4;
    tick();
    if_pc = bp;
    tick();
    checks++;
    if ({debug_en, halted, bp_hit} !== 3'b111) begin
      errors++;
      $display("FAIL bp_rehit got=%b exp=111",
               {debug_en, halted, bp_hit});
    end
    if_pc = 32'hFFFF_0000;
    send(OP_STEP, 32'd1);
    checks++;
    if ({debug_step, bp_hit} !== 2'b10) begin
      errors++;
      $display("FAIL bp_stepclr got=%b exp=10", {debug_step, bp_hit});
    end
    tick();
  endtask

  // Breakpoint wins over a same-cycle STEP accepted in RUN.
  task automatic test_bp_priority(input logic [31:0] bp);
    if_pc = 32'hFFFF_0000;
    send(OP_RUN, 32'd0);
    tick();
    if_pc     = bp;
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    cmd_arg   = 32'd4;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({debug_en, debug_step, halted, bp_hit} !== 4'b1011 ||
        steps_left !== '0) begin
      errors++;
      $display("FAIL bp_prio got=%b steps=%0d exp=1011 steps=0",
               {debug_en, debug_step, halted, bp_hit}, steps_left);
    end
  endtask

  task automatic test_bp_during_step(input logic [31:0] bp);
    if_pc = bp;
    send(OP_STEP, 32'd4);
    checks++;
    if ({debug_step, bp_hit} !== 2'b10 || steps_left !== 16'd4) begin
      errors++;
      $display("FAIL bpstep_hi got=%b steps=%0d exp=10 steps=4",
               {debug_step, bp_hit}, steps_left);
    end
    tick();
    checks++;
    if ({debug_step, halted, bp_hit} !== 3'b011 ||
        steps_left !== '0) begin
      errors++;
      $display("FAIL bpstep_halt got=%b steps=%0d exp=011 steps=0",
               {debug_step, halted, bp_hit}, steps_left);
    end
    if_pc = 32'hFFFF_0000;
    tick();
  endtask

  task automatic test_halt_and_clear;
    send(OP_BP, 32'hFFFF_FFFF);
    send(OP_RUN, 32'd0);
    for (int i = 0; i <= 10; i++) begin
      if_pc = 32'(i * 4);
      tick();
      checks++;
      if ({debug_en, halted} !== 2'b00) begin
        errors++;
        $display("FAIL bpclr_run pc=%h got=%b exp=00", if_pc,
                 {debug_en, halted});
      end
    end
    send(OP_HALT, 32'd0);
    checks++;
    if ({debug_en, halted, bp_hit, cmd_ready} !== 4'b1101) begin
      errors++;
      $display("FAIL halt_cmd got=%b exp=1101",
               {debug_en, halted, bp_hit, cmd_ready});
    end
  endtask

  task automatic test_reset_mid_step;
    send(OP_BP, 32'h0000_0040);
    if_pc = 32'hFFFF_0000;
    send(OP_STEP, 32'd5);
    checks++;
    if (debug_step !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=1", debug_step);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({debug_en, debug_step, halted, cmd_ready, bp_hit} !== 5'b10110 ||
        steps_left !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%b steps=%0d exp=10110 steps=0",
               {debug_en, debug_step, halted, cmd_ready, bp_hit},
               steps_left);
    end
    send(OP_RUN, 32'd0);
    for (int i = 0; i <= 18; i++) begin
      if_pc = 32'(i * 4);
      tick();
      checks++;
      if (debug_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_bpclr pc=%h got=%b exp=0", if_pc, debug_en);
      end
    end
  endtask

  initial begin
    logic [31:0] arg;
    logic [31:0] bp;
    test_reset();
    test_step(32'd3);
    test_step(32'd0);
    for (int r = 0; r < 4; r++) begin
      arg = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(1, 6));
      test_step(arg);
    end
    test_breakpoint(32'h0000_0010);
    bp = 32'($urandom_range(2, 15) * 4);
    test_breakpoint(bp);
    test_bp_priority(bp);
    test_bp_during_step(bp);
    test_halt_and_clear();
    test_reset_mid_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
